dcache_bypass_bridge: RTL and testbench
=======================================

# dcache_bypass_bridge

Non-caching stand-in for the data cache, directly downstream of the CPU core's data bus (the pre-MEM stage issues requests, the MEM stage consumes responses). Each accepted load/store becomes one single-beat AXI4 transaction, with exactly one access outstanding. Used for bring-up and for uncached-only configurations. The `iscache` hint is accepted and ignored.

## Interface
**Parameters**
- `TAG_W`, default 20: width of `tag`.
- `INDEX_W`, default 6: width of `index`.
- `OFFSET_W`, default 6: width of `offset`. `TAG_W+INDEX_W+OFFSET_W` must equal 32.

**Ports** (one clock; reset is asynchronous and active-high)
- `clk`, in, 1: clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `req`, in, 1: CPU request valid.
- `iscache`, in, 1: cacheability hint; ignored.
- `wr`, in, 1: 1 = store, 0 = load.
- `size`, in, 2: 0 = byte, 1 = half, 2 = word.
- `tag`, in, TAG_W: address bits [31:32-TAG_W].
- `index`, in, INDEX_W: middle address bits.
- `offset`, in, OFFSET_W: low address bits.
- `wstrb`, in, 4: store byte enables.
- `wdata`, in, 32: store data.
- `addr_ok`, out, 1: request accepted this cycle.
- `data_ok`, out, 1: one-cycle pulse; the access is complete.
- `rdata`, out, 32: load data, valid while `data_ok`=1.
- AXI master:
  - `arid`/`awid`/`wid`, out, 4 each.
  - `araddr`/`awaddr`, out, 32.
  - `arlen`/`awlen`, out, 8.
  - `arsize`/`awsize`, out, 3.
  - `arburst`/`awburst`, out, 2.
  - `arvalid`, out, 1; `arready`, in, 1.
  - `rdata_axi`, in, 32; `rresp`, in, 2; `rlast`, in, 1; `rvalid`, in, 1; `rready`, out, 1.
  - `awvalid`, out, 1; `awready`, in, 1.
  - `wdata_axi`, out, 32; `wstrb_axi`, out, 4; `wlast`, out, 1; `wvalid`, out, 1; `wready`, in, 1.
  - `bresp`, in, 2; `bvalid`, in, 1; `bready`, out, 1.

## Operation
- Address: `addr = {tag, index, offset}`.
- The request is latched on `req & addr_ok`: addr, `wr`, `size`, `wstrb`, `wdata`.
- Constant outputs:
  - All IDs = 0; `arlen`/`awlen` = 0; bursts = 2'b01 (INCR); `wlast` = 1.
  - `arsize` = `awsize` = {1'b0, latched `size`}.
- State machine:
  - IDLE -> AR if the accepted request is a load.
  - IDLE -> AW_W if the accepted request is a store.
  - AR: `arvalid`=1 with the latched address. On `arready`, go to R.
  - R: `rready`=1. On `rvalid`, capture `rdata_axi` into `rdata`, go to RESP.
  - AW_W: `awvalid` and `wvalid` are driven independently. Each drops after its own handshake (tracked by flags `aw_done`, `w_done`). When both are done, go to B. A same-cycle AW and W handshake satisfies both.
  - B: `bready`=1. On `bvalid`, go to RESP.
  - RESP: `data_ok`=1 for exactly one cycle, then go to IDLE.
- `addr_ok` = (state==IDLE). It is combinational and independent of `req`.
- `rresp` and `bresp` are ignored; the access still completes with `data_ok`.
- `rdata` holds its last captured value until the next load completes. For stores it is don't-care.
- AXI valids never drop before their handshake. Address, data and strobe stay stable while a valid is high.

## Timing
- Reset values: state=IDLE; `addr_ok`=1; `data_ok`=0; `rdata`=0; `arvalid`=`awvalid`=`wvalid`=0; `rready`=`bready`=0; flags cleared.
- Minimum load latency: accept at cycle T; `arvalid` at T+1; with `arready` at T+1, R at T+2; with `rvalid` at T+2, `data_ok` at T+3.
- Minimum store latency: accept at T; AW/W handshake at T+1; B at T+2; `data_ok` at T+3.
- `addr_ok` is 0 from T+1 until the cycle after RESP. No second request is accepted while one is outstanding. Back-to-back throughput is one access per 4 cycles minimum.
- `rready`/`bready` are registered from state, so they are high for the whole R/B state. They are never asserted in other states.
- Reset asserted mid-transaction returns the block to reset values immediately (asynchronously). The outstanding access is abandoned, and no `data_ok` is produced for it.
- `req` asserted during a non-IDLE state is not accepted and not remembered.

## Test plan
- Word load: req, wr=0, addr 0x1FC0_0010, size=2. Slave gives `arready` at once and `rvalid` 3 cycles later with 0xDEAD_BEEF.
  - Required: `araddr`=0x1FC0_0010, `arsize`=2, then a single `data_ok` pulse with `rdata`=0xDEAD_BEEF.
- Byte store: addr 0x0000_0103, size=0, wstrb=4'b1000, wdata=0xAA00_0000. AW accepted 2 cycles before W.
  - Required: `awvalid` drops after its handshake, `wvalid` is held until its handshake, `awsize`=0, then one `data_ok` after `bvalid`.
- Simultaneous AW/W handshake on the first cycle with `bvalid` next cycle.
  - Required: `data_ok` exactly 3 cycles after acceptance.
- Back pressure: `arready` held low for 5 cycles, with `req` kept high.
  - Required: `araddr` is stable, `addr_ok`=0 throughout, and a new request is accepted only after `data_ok`.
- Error response: `rresp`=2'b10.
  - Required: `data_ok` still pulses once and `rdata` captures the bus value.
- Reset asserted while in R.
  - Required: all valids/readies are 0, `addr_ok`=1 in the same cycle, and no `data_ok`. A following load completes normally.

Source files
------------

// File: rtl/dcache_bypass_bridge.sv
// Uncached data-bus bridge: turns each accepted CPU load/store into one
// single-beat AXI4 transaction, with exactly one access outstanding at a time.
module dcache_bypass_bridge #(
  parameter int TAG_W    = 20,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  // CPU side
  input  logic                req,
  input  logic                iscache,
  input  logic                wr,
  input  logic [1:0]          size,
  input  logic [TAG_W-1:0]    tag,
  input  logic [INDEX_W-1:0]  index,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [3:0]          wstrb,
  input  logic [31:0]         wdata,
  output logic                addr_ok,
  output logic                data_ok,
  output logic [31:0]         rdata,
  // AXI read address
  output logic [3:0]          arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  // AXI read data
  input  logic [31:0]         rdata_axi,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  // AXI write address
  output logic [3:0]          awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  // AXI write data
  output logic [3:0]          wid,
  output logic [31:0]         wdata_axi,
  output logic [3:0]          wstrb_axi,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // AXI write response
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  // FSM state, for observation only
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_data_ok;
  logic        r_aw_done;
  logic        r_w_done;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_aw_fin;
  logic        w_w_fin;
  logic        w_unused;

  // Valid/ready: a transfer happens on a rising edge where both valid and
  // ready are high; a valid, once raised, holds with stable payload until then.
  assign w_aw_hs  = r_awvalid & awready;
  assign w_w_hs   = r_wvalid & wready;
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done | w_w_hs;

  // Cacheability hint and response codes do not influence the access.
  assign w_unused = ^{iscache, rresp, rlast, bresp};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_size    <= '0;
      r_wstrb   <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_data_ok <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_addr  <= {tag, index, offset};
            r_size  <= size;
            r_wstrb <= wstrb;
            r_wdata <= wdata;
            if (wr) begin
              r_state   <= S_AW_W;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end else begin
              r_state   <= S_AR;
              r_arvalid <= 1'b1;
            end
          end
        end
        S_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (rvalid) begin
            r_rdata   <= rdata_axi;
            r_rready  <= 1'b0;
            r_data_ok <= 1'b1;
            r_state   <= S_RESP;
          end
        end
        S_AW_W: begin
          // AW and W complete independently; the flags remember which one is done.
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_B;
          end
        end
        S_B: begin
          if (bvalid) begin
            r_bready  <= 1'b0;
            r_data_ok <= 1'b1;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          r_data_ok <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign addr_ok   = (r_state == S_IDLE);
  assign data_ok   = r_data_ok;
  assign rdata     = r_rdata;
  assign dbg_state = r_state;

  assign arid      = 4'd0;
  assign araddr    = r_addr;
  assign arlen     = 8'd0;
  assign arsize    = {1'b0, r_size};
  assign arburst   = 2'b01;
  assign arvalid   = r_arvalid;
  assign rready    = r_rready;

  assign awid      = 4'd0;
  assign awaddr    = r_addr;
  assign awlen     = 8'd0;
  assign awsize    = {1'b0, r_size};
  assign awburst   = 2'b01;
  assign awvalid   = r_awvalid;

  assign wid       = 4'd0;
  assign wdata_axi = r_wdata;
  assign wstrb_axi = r_wstrb;
  assign wlast     = 1'b1;
  assign wvalid    = r_wvalid;
  assign bready    = r_bready;

endmodule

// File: tb/tb_dcache_bypass_bridge.sv
// Directed bench for dcache_bypass_bridge: a cycle-timing model of each access
// predicts every handshake window, checked on every falling edge.
module tb_dcache_bypass_bridge;
  localparam int TAG_W    = 20;
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic                req, iscache, wr;
  logic [1:0]          size;
  logic [TAG_W-1:0]    tag;
  logic [INDEX_W-1:0]  index;
  logic [OFFSET_W-1:0] offset;
  logic [3:0]          wstrb;
  logic [31:0]         wdata;
  logic                addr_ok, data_ok;
  logic [31:0]         rdata;
  logic [3:0]          arid, awid, wid;
  logic [31:0]         araddr, awaddr;
  logic [7:0]          arlen, awlen;
  logic [2:0]          arsize, awsize;
  logic [1:0]          arburst, awburst;
  logic                arvalid, arready;
  logic [31:0]         rdata_axi;
  logic [1:0]          rresp;
  logic                rlast, rvalid, rready;
  logic                awvalid, awready;
  logic [31:0]         wdata_axi;
  logic [3:0]          wstrb_axi;
  logic                wlast, wvalid, wready;
  logic [1:0]          bresp;
  logic                bvalid, bready;
  logic [2:0]          dbg_state;

  dcache_bypass_bridge #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W)) dut (
    .clk(clk), .reset(reset),
    .req(req), .iscache(iscache), .wr(wr), .size(size),
    .tag(tag), .index(index), .offset(offset),
    .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata_axi(wdata_axi), .wstrb_axi(wstrb_axi), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One access described by acceptance cycle and slave delays:
  // load: d1 = arready delay, d2 = rvalid delay after entering R
  // store: d1 = awready delay, d2 = wready delay, d3 = bvalid delay
  bit          m_active = 1'b0;
  bit          m_wr;
  int          m_T, m_d1, m_d2, m_d3, m_done;
  logic [31:0] m_addr, m_wdata, m_rval;
  logic [31:0] m_hold = 32'd0;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] exp_q[$];

  int          obs_lat = -1;
  int          obs_cnt = 0;
  logic [31:0] obs_rdata = 32'd0;

  logic e_addr_ok, e_data_ok, e_arv, e_rr, e_awv, e_wv, e_br;
  logic [31:0] e_rdata;
  int   mx;

  always @(negedge clk) begin
    mx        = max2(m_d1, m_d2);
    e_addr_ok = !(m_active && cyc > m_T && cyc <= m_done);
    e_data_ok = m_active && cyc == m_done;
    e_arv = m_active && !m_wr && cyc >= m_T + 1 && cyc <= m_T + 1 + m_d1;
    e_rr  = m_active && !m_wr && cyc >= m_T + 2 + m_d1 && cyc <= m_T + 2 + m_d1 + m_d2;
    e_awv = m_active && m_wr && cyc >= m_T + 1 && cyc <= m_T + 1 + m_d1;
    e_wv  = m_active && m_wr && cyc >= m_T + 1 && cyc <= m_T + 1 + m_d2;
    e_br  = m_active && m_wr && cyc >= m_T + 2 + mx && cyc <= m_T + 2 + mx + m_d3;
    e_rdata = (m_active && !m_wr && cyc >= m_done) ? m_rval : m_hold;

    chk("addr_ok", {31'd0, addr_ok}, {31'd0, e_addr_ok});
    chk("data_ok", {31'd0, data_ok}, {31'd0, e_data_ok});
    chk("arvalid", {31'd0, arvalid}, {31'd0, e_arv});
    chk("rready",  {31'd0, rready},  {31'd0, e_rr});
    chk("awvalid", {31'd0, awvalid}, {31'd0, e_awv});
    chk("wvalid",  {31'd0, wvalid},  {31'd0, e_wv});
    chk("bready",  {31'd0, bready},  {31'd0, e_br});
    chk("rdata",   rdata, e_rdata);
    chk("axi_const", {8'd0, arid, awid, wid, arlen, arburst, awburst, wlast, 1'b0},
                     {8'd0, 4'd0, 4'd0, 4'd0, 8'd0, 2'b01, 2'b01, 1'b1, 1'b0});
    chk("awlen", {24'd0, awlen}, 32'd0);
    if (e_arv) begin
      chk("araddr", araddr, m_addr);
      chk("arsize", {29'd0, arsize}, {30'd0, m_size});
    end
    if (e_awv) begin
      chk("awaddr", awaddr, m_addr);
      chk("awsize", {29'd0, awsize}, {30'd0, m_size});
    end
    if (e_wv) begin
      chk("wdata_axi", wdata_axi, m_wdata);
      chk("wstrb_axi", {28'd0, wstrb_axi}, {28'd0, m_wstrb});
    end
    if (data_ok) begin
      obs_cnt++;
      obs_lat   = cyc - m_T;
      obs_rdata = rdata;
      if (m_active && !m_wr && exp_q.size() > 0) chk("sb_rdata", rdata, exp_q.pop_front());
    end
    if (e_data_ok && !m_wr) m_hold = m_rval;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_slave();
    arready = 1'b0; rvalid = 1'b0; rdata_axi = 32'd0; rresp = 2'd0; rlast = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req = 1'b0;
    end
  endtask

  // Runs one access; the slave side is driven by cycle number from the delays.
  // abort_at > 0 asserts reset that many cycles after acceptance.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [1:0] sz,
                         input logic [3:0] st, input logic [31:0] wd,
                         input int d1, input int d2, input int d3,
                         input logic [31:0] rv, input logic [1:0] rsp,
                         input logic hold, input int abort_at);
    int k;
    @(posedge clk); #1;
    req = 1'b1; wr = w; size = sz; wstrb = st; wdata = wd;
    tag = a[31 -: TAG_W]; index = a[OFFSET_W +: INDEX_W]; offset = a[OFFSET_W-1:0];
    iscache = 1'($urandom_range(0, 1));
    k = max2(d1, d2);
    m_wr = w; m_T = cyc; m_d1 = d1; m_d2 = d2; m_d3 = w ? d3 : 0;
    m_addr = a; m_size = sz; m_wstrb = st; m_wdata = wd; m_rval = rv;
    m_done = w ? cyc + 3 + k + d3 : cyc + 3 + d1 + d2;
    m_active = 1'b1;
    obs_cnt = 0; obs_lat = -1;
    if (!w) exp_q.push_back(rv);
    while (cyc < m_done) begin
      @(posedge clk); #1;
      req       = hold;
      arready   = !w && cyc == m_T + 1 + d1;
      rvalid    = !w && cyc == m_T + 2 + d1 + d2;
      rdata_axi = rvalid ? rv : $urandom;
      rresp     = rsp;
      rlast     = rvalid;
      awready   = w && cyc == m_T + 1 + d1;
      wready    = w && cyc == m_T + 1 + d2;
      bvalid    = w && cyc == m_T + 2 + k + d3;
      bresp     = rsp;
      if (abort_at > 0 && cyc == m_T + abort_at) begin
        #1 reset = 1'b1;
        #1;
        chk("rst_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
        chk("rst_addr_ok", {31'd0, addr_ok}, 32'd1);
        chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        m_active = 1'b0;
        m_hold   = 32'd0;
        exp_q.delete();
        clear_slave();
        req = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        return;
      end
    end
    @(negedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    req = 1'b0; iscache = 1'b0; wr = 1'b0; size = 2'd0;
    tag = '0; index = '0; offset = '0; wstrb = 4'd0; wdata = 32'd0;
    clear_slave();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // word load, arready at once, rvalid three cycles after arready
    run_txn(1'b0, 32'h1FC0_0010, 2'd2, 4'h0, 32'h0, 0, 2, 0, 32'hDEAD_BEEF, 2'd0, 1'b0, 0);
    chk("t_load_lat", obs_lat, 5);
    chk("t_load_cnt", obs_cnt, 1);
    chk("t_load_rdata", obs_rdata, 32'hDEAD_BEEF);
    idle(2);

    // byte store, AW two cycles before W, bvalid one cycle into B
    run_txn(1'b1, 32'h0000_0103, 2'd0, 4'b1000, 32'hAA00_0000, 0, 2, 1, 32'h0, 2'd0, 1'b0, 0);
    chk("t_bstore_lat", obs_lat, 6);
    chk("t_bstore_cnt", obs_cnt, 1);

    // simultaneous AW/W, bvalid at once: minimum store latency
    run_txn(1'b1, 32'h8000_0040, 2'd2, 4'hF, 32'h1234_5678, 0, 0, 0, 32'h0, 2'd0, 1'b0, 0);
    chk("t_sim_lat", obs_lat, 3);

    // W before AW, halfword
    run_txn(1'b1, 32'h4000_0A02, 2'd1, 4'b1100, 32'hBEEF_0000, 3, 1, 0, 32'h0, 2'd0, 1'b0, 0);
    chk("t_wfirst_lat", obs_lat, 6);
    idle(1);

    // arready held low five cycles with req held high; next load follows at once
    run_txn(1'b0, 32'h2000_1234, 2'd2, 4'h0, 32'h0, 5, 0, 0, 32'h0123_4567, 2'd0, 1'b1, 0);
    chk("t_bp_lat", obs_lat, 8);
    chk("t_bp_rdata", obs_rdata, 32'h0123_4567);
    run_txn(1'b0, 32'h2000_1238, 2'd0, 4'h0, 32'h0, 0, 0, 0, 32'h0BAD_F00D, 2'd0, 1'b0, 0);
    chk("t_b2b_lat", obs_lat, 3);
    chk("t_b2b_rdata", obs_rdata, 32'h0BAD_F00D);

    // error response still completes and captures data
    run_txn(1'b0, 32'h0000_0FFC, 2'd2, 4'h0, 32'h0, 0, 1, 0, 32'hCAFE_0001, 2'b10, 1'b0, 0);
    chk("t_err_lat", obs_lat, 4);
    chk("t_err_rdata", obs_rdata, 32'hCAFE_0001);

    // store with SLVERR; rdata keeps the last load value
    run_txn(1'b1, 32'hFFFF_FFFC, 2'd2, 4'hF, 32'h5A5A_A5A5, 1, 1, 2, 32'h0, 2'b10, 1'b0, 0);
    chk("t_serr_lat", obs_lat, 6);
    idle(2);

    // reset while in R abandons the access
    run_txn(1'b0, 32'h1FC0_0020, 2'd2, 4'h0, 32'h0, 0, 3, 0, 32'h7777_7777, 2'd0, 1'b0, 3);
    idle(6);
    chk("t_rst_no_data_ok", obs_cnt, 0);

    run_txn(1'b0, 32'h1FC0_0024, 2'd2, 4'h0, 32'h0, 0, 0, 0, 32'h55AA_33CC, 2'd0, 1'b0, 0);
    chk("t_post_rst_lat", obs_lat, 3);
    chk("t_post_rst_rdata", obs_rdata, 32'h55AA_33CC);
    chk("t_sb_empty", exp_q.size(), 0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
